// File: rtl/bin_to_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter_if
//   Bundles the input handshake and the result bus of bin_to_bcd_converter.
//
//   Signals:
//     bin_in        unsigned binary value, sampled on an accepted transfer
//     valid_in      request to convert bin_in
//     ready_out     converter idle and able to accept
//     bcd_out       packed BCD result, digit 0 in bcd_out[3:0]
//     valid_out     one-cycle pulse when bcd_out updates
//     overflow_out  last accepted value did not fit in DIGITS digits
//
//   Modports:
//     master  producer of values / consumer of results (e.g. testbench)
//     slave   the converter itself
// ---------------------------------------------------------------------------
interface bin_to_bcd_converter_if #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
);

  logic [BIN_W-1:0]    bin_in;
  logic                valid_in;
  logic                ready_out;
  logic [4*DIGITS-1:0] bcd_out;
  logic                valid_out;
  logic                overflow_out;

  modport master (
    output bin_in,
    output valid_in,
    input  ready_out,
    input  bcd_out,
    input  valid_out,
    input  overflow_out
  );

  modport slave (
    input  bin_in,
    input  valid_in,
    output ready_out,
    output bcd_out,
    output valid_out,
    output overflow_out
  );

endinterface

// File: rtl/bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter
//   Sequential double-dabble converter: turns an unsigned BIN_W-bit value
//   into DIGITS packed BCD digits, one input bit per clock. Feeds the
//   seven-segment controller so the display reads in decimal.
//
//   Ports:
//     clk_in    system clock
//     rst_n_in  asynchronous, active-low reset
//     bus       bin_to_bcd_converter_if.slave
//                 bin_in / valid_in / ready_out : one-transfer input handshake
//                 bcd_out / overflow_out        : registered result, held
//                                                 until the next result
//                 valid_out                     : one-cycle update pulse
//
//   Latency: result visible BIN_W+1 edges after the accepting edge.
//
//   Build option:
//     BCD_SATURATE_EN  when defined, an overflowing value is shown as all
//                      nines; otherwise the low DIGITS digits are shown
//                      (value mod 10^DIGITS). overflow_out is set either way.
// ---------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  bin_to_bcd_converter_if.slave bus
);

  // One spare digit above the visible ones holds the overflow magnitude.
  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [127:0] pow10(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 128'd10;
    end
    return r;
  endfunction

  localparam logic [127:0] MAX_VAL = pow10(DIGITS) - 128'd1;

  // The accumulator (DIGITS+1 digits) must be able to hold any input value.
  generate
    if ((128'd1 << BIN_W) > pow10(DIGITS + 1)) begin : g_width_check
      $fatal(1, "bin_to_bcd_converter: 2^BIN_W exceeds 10^(DIGITS+1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_out_q, ovf_out_d;
  logic                valid_q, valid_d;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic                accept;

  assign accept = bus.valid_in && (state_q == IDLE);

  // Double-dabble step: add 3 to every digit >= 5, then shift the combined
  // {accumulator, binary} left by one so the binary MSB enters digit 0.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d <= DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, bin_q} << 1;
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_out_d  = ovf_out_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bin_d      = bus.bin_in;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_flag_d = (128'(bus.bin_in) > MAX_VAL);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        acc_d = shifted[ACC_W+BIN_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q == 1 means this edge performs the last of BIN_W shifts.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
`ifdef BCD_SATURATE_EN
        bcd_d = ovf_flag_q ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
`else
        bcd_d = acc_q[4*DIGITS-1:0];
`endif
        ovf_out_d = ovf_flag_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      ovf_out_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_out_q  <= ovf_out_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.ready_out    = (state_q == IDLE);
  assign bus.bcd_out      = bcd_q;
  assign bus.overflow_out = ovf_out_q;
  assign bus.valid_out    = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_converter
//   Directed testbench for bin_to_bcd_converter at BIN_W=27, DIGITS=8.
//   Expected BCD values are hand-computed; overflow cases follow
//   BCD_SATURATE_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_converter;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;

`ifdef BCD_SATURATE_EN
  localparam logic [31:0] EXP_1E8 = 32'h99999999;
  localparam logic [31:0] EXP_MAX = 32'h99999999;
`else
  localparam logic [31:0] EXP_1E8 = 32'h00000000;
  localparam logic [31:0] EXP_MAX = 32'h34217727;
`endif

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_converter_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bcd_bus ();

  bin_to_bcd_converter #(
    .BIN_W (BIN_W),
    .DIGITS(DIGITS)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bcd_bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present a value with valid_in until the accepting edge, then drop valid.
  task automatic applyStimulus(input logic [BIN_W-1:0] value);
    int guard;
    guard = 0;
    bcd_bus.bin_in   = value;
    bcd_bus.valid_in = 1'b1;
    while (bcd_bus.ready_out !== 1'b1 && guard < 100) begin
      @(posedge clk_in);
      #1;
      guard++;
    end
    checkOutput("accept_ready", {63'd0, bcd_bus.ready_out}, 64'd1);
    @(posedge clk_in);
    #1;
    bcd_bus.valid_in = 1'b0;
  endtask

  // Count edges after the accepting edge until valid_out is seen (0 = timeout).
  task automatic waitResult(output int edges);
    edges = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk_in);
      #1;
      if (bcd_bus.valid_out === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int pulses;
    int readyEarly;
    int seenDone;
    logic [31:0] capBcd;
    logic        capOvf;

    bcd_bus.bin_in   = '0;
    bcd_bus.valid_in = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_ready", {63'd0, bcd_bus.ready_out}, 64'd1);
    checkOutput("rst_bcd", {32'd0, bcd_bus.bcd_out}, 64'd0);
    checkOutput("rst_valid", {63'd0, bcd_bus.valid_out}, 64'd0);
    checkOutput("rst_ovf", {63'd0, bcd_bus.overflow_out}, 64'd0);
    #6;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // 12345678, latency and single-cycle pulse
    $display("[TB] converting 12345678");
    applyStimulus(27'd12345678);
    checkOutput("t1_ready_drop", {63'd0, bcd_bus.ready_out}, 64'd0);
    waitResult(edges);
    checkOutput("t1_latency", 64'(edges), 64'd28);
    checkOutput("t1_bcd", {32'd0, bcd_bus.bcd_out}, 64'h12345678);
    checkOutput("t1_ovf", {63'd0, bcd_bus.overflow_out}, 64'd0);
    @(posedge clk_in);
    #1;
    checkOutput("t1_pulse_end", {63'd0, bcd_bus.valid_out}, 64'd0);
    checkOutput("t1_hold", {32'd0, bcd_bus.bcd_out}, 64'h12345678);

    // 0 then 99999999 back-to-back with valid_in held high
    $display("[TB] back-to-back 0 / 99999999");
    bcd_bus.bin_in   = 27'd0;
    bcd_bus.valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    bcd_bus.bin_in = 27'd99999999;
    waitResult(edges);
    checkOutput("t2a_latency", 64'(edges), 64'd28);
    checkOutput("t2a_bcd", {32'd0, bcd_bus.bcd_out}, 64'h0);
    checkOutput("t2a_ovf", {63'd0, bcd_bus.overflow_out}, 64'd0);
    checkOutput("t2a_ready_back", {63'd0, bcd_bus.ready_out}, 64'd1);
    @(posedge clk_in);
    #1;
    bcd_bus.valid_in = 1'b0;
    checkOutput("t2b_accepted", {63'd0, bcd_bus.ready_out}, 64'd0);
    waitResult(edges);
    checkOutput("t2b_latency", 64'(edges), 64'd28);
    checkOutput("t2b_bcd", {32'd0, bcd_bus.bcd_out}, 64'h99999999);
    checkOutput("t2b_ovf", {63'd0, bcd_bus.overflow_out}, 64'd0);

    // 100000000: first overflowing value
    $display("[TB] converting 100000000");
    applyStimulus(27'd100000000);
    waitResult(edges);
    checkOutput("t3_latency", 64'(edges), 64'd28);
    checkOutput("t3_bcd", {32'd0, bcd_bus.bcd_out}, {32'd0, EXP_1E8});
    checkOutput("t3_ovf", {63'd0, bcd_bus.overflow_out}, 64'd1);

    // All ones
    $display("[TB] converting 134217727");
    applyStimulus(27'h7FFFFFF);
    waitResult(edges);
    checkOutput("t4_bcd", {32'd0, bcd_bus.bcd_out}, {32'd0, EXP_MAX});
    checkOutput("t4_ovf", {63'd0, bcd_bus.overflow_out}, 64'd1);

    // 42 with an ignored request mid-SHIFT
    $display("[TB] converting 42 with stray request");
    applyStimulus(27'd42);
    repeat (10) @(posedge clk_in);
    #1;
    bcd_bus.bin_in   = 27'd7;
    bcd_bus.valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    bcd_bus.valid_in = 1'b0;
    checkOutput("t5_busy", {63'd0, bcd_bus.ready_out}, 64'd0);
    pulses     = 0;
    readyEarly = 0;
    seenDone   = 0;
    capBcd     = '0;
    capOvf     = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk_in);
      #1;
      if (bcd_bus.valid_out === 1'b1) begin
        pulses++;
        seenDone = 1;
        capBcd   = bcd_bus.bcd_out;
        capOvf   = bcd_bus.overflow_out;
      end
      if (seenDone == 0 && bcd_bus.ready_out === 1'b1) readyEarly = 1;
    end
    checkOutput("t5_pulses", 64'(pulses), 64'd1);
    checkOutput("t5_ready_early", 64'(readyEarly), 64'd0);
    checkOutput("t5_bcd", {32'd0, capBcd}, 64'h42);
    checkOutput("t5_ovf", {63'd0, capOvf}, 64'd0);

    // 555 interrupted by asynchronous reset
    $display("[TB] converting 555 with reset mid-shift");
    applyStimulus(27'd555);
    repeat (5) @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    checkOutput("t6_rst_bcd", {32'd0, bcd_bus.bcd_out}, 64'h0);
    checkOutput("t6_rst_ready", {63'd0, bcd_bus.ready_out}, 64'd1);
    checkOutput("t6_rst_valid", {63'd0, bcd_bus.valid_out}, 64'd0);
    repeat (2) @(posedge clk_in);
    #3;
    rst_n_in = 1'b1;
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk_in);
      #1;
      if (bcd_bus.valid_out === 1'b1) pulses++;
    end
    checkOutput("t6_no_pulse", 64'(pulses), 64'd0);
    applyStimulus(27'd555);
    waitResult(edges);
    checkOutput("t6_latency", 64'(edges), 64'd28);
    checkOutput("t6_bcd", {32'd0, bcd_bus.bcd_out}, 64'h555);
    checkOutput("t6_ovf", {63'd0, bcd_bus.overflow_out}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
